// File: rtl/ro_run_timer_pkg.sv
// Shared types and defaults for the ring-oscillator run timer.
package ro_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } timerState_e;

  localparam int RO_TIMER_CNT_W       = 24;
  localparam int RO_TIMER_SYNC_STAGES = 2;

  function automatic int bytes_of(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/ro_run_timer_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, plus a delay flop for edge detection.
module ro_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_delay;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   w_primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_delay <= 1'b0;
      r_fill  <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_delay <= r_sync[SYNC_STAGES-1];
      r_fill  <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain has refilled after reset, so a pin
  // held high through reset does not look like a fresh rising edge.
  assign w_primed = r_fill[SYNC_STAGES];
  assign level    = r_sync[SYNC_STAGES-1];
  assign rise     = w_primed &  r_sync[SYNC_STAGES-1] & ~r_delay;
  assign fall     = w_primed & ~r_sync[SYNC_STAGES-1] &  r_delay;

endmodule

// File: rtl/ro_run_timer.sv
// Counts reference-clock cycles while the worker runs and serves the total bytewise.
module ro_run_timer
  import ro_timer_pkg::*;
#(
  parameter  int CNT_W       = RO_TIMER_CNT_W,
  parameter  int SYNC_STAGES = RO_TIMER_SYNC_STAGES,
  localparam int NBYTES      = bytes_of(CNT_W),
  localparam int BIDX_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_in,
  input  logic              done_in,
  input  logic              rd_in,
  output logic [7:0]        dout,
  output logic [BIDX_W-1:0] byte_idx,
  output logic              busy,
  output logic              valid,
  output logic              aborted,
  output logic              ovf
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [BIDX_W-1:0] IDX_LAST = BIDX_W'(NBYTES - 1);

  timerState_e       r_state;
  timerState_e       w_stateNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_result;
  logic [BIDX_W-1:0] r_byteIdx;
  logic              r_valid;
  logic              r_aborted;
  logic              r_ovf;
  logic              w_runLevel, w_runRise, w_runFall;
  logic              w_doneLevel, w_doneRise, w_doneFall;
  logic              w_rdLevel, w_rdRise, w_rdFall;
  logic              w_unusedEdges;
  logic [7:0]        w_dout;

  ro_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_runSync (
    .clk(clk), .rst(rst), .i_pin(run_in),
    .level(w_runLevel), .rise(w_runRise), .fall(w_runFall)
  );

  ro_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_doneSync (
    .clk(clk), .rst(rst), .i_pin(done_in),
    .level(w_doneLevel), .rise(w_doneRise), .fall(w_doneFall)
  );

  ro_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rdSync (
    .clk(clk), .rst(rst), .i_pin(rd_in),
    .level(w_rdLevel), .rise(w_rdRise), .fall(w_rdFall)
  );

  assign w_unusedEdges = &{1'b0, w_doneRise, w_doneFall, w_rdLevel, w_rdFall};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_runRise) w_stateNext = COUNT;
      COUNT:   if (w_runFall) w_stateNext = SETTLE;
      SETTLE:  w_stateNext = HOLD;
      HOLD:    if (w_runRise) w_stateNext = COUNT;
      default: w_stateNext = IDLE;
    endcase
  end

  // A new run always wins over readout, even when rd rises in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_result  <= '0;
      r_byteIdx <= '0;
      r_valid   <= 1'b0;
      r_aborted <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_runRise) begin
            r_cnt     <= CNT_W'(1);
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_aborted <= 1'b0;
            r_byteIdx <= '0;
          end else if ((r_state == HOLD) && w_rdRise) begin
            r_byteIdx <= (r_byteIdx == IDX_LAST) ? '0 : r_byteIdx + BIDX_W'(1);
          end
        end
        COUNT: begin
          if (w_runLevel) begin
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_MAX - CNT_W'(1)) r_ovf <= 1'b1;
            end
          end else if (w_runFall) begin
            r_result <= r_cnt;
          end
        end
        SETTLE: begin
          r_aborted <= ~w_doneLevel;
          r_valid   <= 1'b1;
          r_byteIdx <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dout = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_byteIdx == BIDX_W'(i)) w_dout = r_result[8*i +: 8];
    end
  end

  assign dout     = r_valid ? w_dout : 8'h00;
  assign byte_idx = r_byteIdx;
  assign busy     = (r_state == COUNT) | (r_state == SETTLE);
  assign valid    = r_valid;
  assign aborted  = r_aborted;
  assign ovf      = r_ovf;

endmodule
